// File: rtl/io_port_if.sv
// Processor-style I/O port bus shared by the arbiter (master) and the
// downstream address decoder / peripherals (slave).
interface io_port_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [AW-1:0] port_id;
    logic [DW-1:0] out_port;
    logic          write_strobe;
    logic          read_strobe;
    logic [DW-1:0] in_port;

    modport master (
        output port_id,
        output out_port,
        output write_strobe,
        output read_strobe,
        input  in_port
    );

    modport slave (
        input  port_id,
        input  out_port,
        input  write_strobe,
        input  read_strobe,
        output in_port
    );
endinterface

// File: rtl/io_port_arbiter.sv
// Round-robin arbiter that turns one granted request at a time into a
// single setup cycle, a single-cycle strobe and a one-cycle ack on the
// shared I/O port bus. Read data is captured at the end of the strobe cycle.
module io_port_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 16,
    parameter int DW   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    io_port_if.master          bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        STROBE = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   ptr_r;
    logic            we_r;
    logic [NREQ-1:0] gnt_r;
    logic [NREQ-1:0] ack_r;
    logic [DW-1:0]   rdata_r;
    logic [AW-1:0]   port_id_r;
    logic [DW-1:0]   out_port_r;
    logic            write_strobe_r;
    logic            read_strobe_r;

    logic [AW-1:0]   addr_s  [NREQ];
    logic [DW-1:0]   wdata_s [NREQ];
    logic            win_found_s;
    logic [IW-1:0]   win_idx_s;
    logic [IW-1:0]   cand_idx_s;
    logic [IW-1:0]   next_ptr_s;

    // Split the flat per-requester address/data buses into arrays
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_s[i]  = addr[i*AW +: AW];
            wdata_s[i] = wdata[i*DW +: DW];
        end
    end

    // Round-robin search: first active request at or after the priority pointer
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_idx_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_idx_s = IW'((int'(ptr_r) + i) % NREQ);
            if (!win_found_s && req[cand_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
        if (win_idx_s == IW'(NREQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = win_idx_s + 1'b1;
        end
    end

    // Transaction sequencer: grant/latch, setup, strobe, acknowledge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            ptr_r          <= '0;
            we_r           <= 1'b0;
            gnt_r          <= '0;
            ack_r          <= '0;
            rdata_r        <= '0;
            port_id_r      <= '0;
            out_port_r     <= '0;
            write_strobe_r <= 1'b0;
            read_strobe_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r <= '0;
                    if (win_found_s) begin
                        state_r   <= ADDR;
                        ptr_r     <= next_ptr_s;
                        we_r      <= we[win_idx_s];
                        gnt_r     <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
                        port_id_r <= addr_s[win_idx_s];
                        // A read leaves the last written data on out_port
                        if (we[win_idx_s]) begin
                            out_port_r <= wdata_s[win_idx_s];
                        end
                    end
                end
                ADDR: begin
                    state_r        <= STROBE;
                    write_strobe_r <= we_r;
                    read_strobe_r  <= ~we_r;
                end
                STROBE: begin
                    state_r        <= ACK;
                    write_strobe_r <= 1'b0;
                    read_strobe_r  <= 1'b0;
                    ack_r          <= gnt_r;
                    if (!we_r) begin
                        rdata_r <= bus.in_port;
                    end
                end
                ACK: begin
                    state_r <= IDLE;
                    ack_r   <= '0;
                    gnt_r   <= '0;
                end
                default: begin
                    state_r        <= IDLE;
                    gnt_r          <= '0;
                    ack_r          <= '0;
                    write_strobe_r <= 1'b0;
                    read_strobe_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt              = gnt_r;
    assign ack              = ack_r;
    assign rdata            = rdata_r;
    assign bus.port_id      = port_id_r;
    assign bus.out_port     = out_port_r;
    assign bus.write_strobe = write_strobe_r;
    assign bus.read_strobe  = read_strobe_r;
endmodule

// File: tb/tb_io_port_arbiter.sv
// Randomized bench for io_port_arbiter. Requesters follow the handshake
// (hold until granted, scramble fields after grant, drop or re-request after
// ack); a transaction-level model predicts every output cycle by cycle from
// the grant time, round-robin rule and latency rules.
module tb_io_port_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int NCYC = 800;

    logic               clk;
    logic               reset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;

    io_port_if #(.AW(AW), .DW(DW)) bus ();

    io_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .gnt     (gnt),
        .ack     (ack),
        .rdata   (rdata),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (transaction level)
    int            cyc;
    bit            busy;
    int            g;          // edge at which the current grant happened
    int            win;
    int            last;       // last winner; search starts at last+1
    bit            m_we;
    logic [AW-1:0] e_port;
    logic [DW-1:0] e_out;
    logic [DW-1:0] e_rdata;
    int            grants [NREQ];

    // Requester driver state: 0 idle, 1 waiting for grant, 2 in flight
    int st [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        busy    = 1'b0;
        g       = 0;
        win     = 0;
        last    = NREQ - 1;
        m_we    = 1'b0;
        e_port  = '0;
        e_out   = '0;
        e_rdata = '0;
    endtask

    // Advance the model across one active clock edge using the inputs seen there
    task automatic model_step();
        int c;
        if (busy) begin
            if (cyc == g + 2 && !m_we) e_rdata = bus.in_port;
            if (cyc == g + 3) busy = 1'b0;
        end else begin
            for (int i = 1; i <= NREQ; i++) begin
                c = (last + i) % NREQ;
                if (!busy && req[c]) begin
                    busy   = 1'b1;
                    g      = cyc;
                    win    = c;
                    last   = c;
                    m_we   = we[c];
                    e_port = addr[c*AW +: AW];
                    if (m_we) e_out = wdata[c*DW +: DW];
                    grants[c]++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int off;
        logic [NREQ-1:0] e_gnt, e_ack;
        logic e_ws, e_rs;
        off   = cyc - g;
        e_gnt = busy ? NREQ'(1 << win) : '0;
        e_ack = (busy && off == 2) ? NREQ'(1 << win) : '0;
        e_ws  = busy && off == 1 && m_we;
        e_rs  = busy && off == 1 && !m_we;
        chk("gnt",          32'(gnt),              32'(e_gnt));
        chk("ack",          32'(ack),              32'(e_ack));
        chk("write_strobe", 32'(bus.write_strobe), 32'(e_ws));
        chk("read_strobe",  32'(bus.read_strobe),  32'(e_rs));
        chk("port_id",      32'(bus.port_id),      32'(e_port));
        chk("out_port",     32'(bus.out_port),     32'(e_out));
        chk("rdata",        32'(rdata),            32'(e_rdata));
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (st[i] == 2 && busy && win == i && cyc - g == 2) st[i] = 0;
            if (st[i] == 1 && busy && win == i) st[i] = 2;
            if (st[i] == 2) begin
                // Post-grant changes must be ignored by the arbiter
                req[i]            = 1'b1;
                we[i]             = 1'($urandom);
                addr[i*AW +: AW]  = AW'($urandom);
                wdata[i*DW +: DW] = DW'($urandom);
            end else if (st[i] == 1) begin
                if ($urandom_range(0, 7) == 0) begin
                    st[i]  = 0;
                    req[i] = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                st[i]             = 1;
                req[i]            = 1'b1;
                we[i]             = 1'($urandom);
                addr[i*AW +: AW]  = AW'($urandom);
                wdata[i*DW +: DW] = DW'($urandom);
            end else begin
                req[i] = 1'b0;
            end
        end
        bus.in_port = DW'($urandom);
    endtask

    initial begin
        bit did_rst;
        did_rst     = 1'b0;
        cyc         = 0;
        reset_n     = 1'b0;
        req         = '0;
        we          = '0;
        addr        = '0;
        wdata       = '0;
        bus.in_port = '0;
        for (int i = 0; i < NREQ; i++) begin
            st[i]     = 0;
            grants[i] = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
        drive();

        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            cyc++;
            model_step();
            @(negedge clk);
            check_outputs();
            if (!did_rst && cyc > 300 && busy && cyc - g == 1) begin
                // Reset in the strobe cycle: everything clears at once, no ack
                did_rst = 1'b1;
                reset_n = 1'b0;
                #1;
                chk("rst_strobe", 32'(bus.write_strobe | bus.read_strobe), 32'd0);
                chk("rst_gnt",    32'(gnt),         32'd0);
                chk("rst_port",   32'(bus.port_id), 32'd0);
                model_reset();
                req = '0;
                for (int i = 0; i < NREQ; i++) st[i] = 0;
                @(posedge clk);
                @(negedge clk);
                chk("rst_ack", 32'(ack), 32'd0);
                reset_n          = 1'b1;
                st[0]            = 1;
                req[0]           = 1'b1;
                we[0]            = 1'b1;
                addr[0 +: AW]    = 16'h8004;
                wdata[0 +: DW]   = 16'h5A5A;
            end else begin
                drive();
            end
        end
        for (int i = 0; i < NREQ; i++) chk("served", 32'(grants[i] > 10), 32'd1);
        chk("reset_hit", 32'(did_rst), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
